// File: rtl/seven_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_mux
//
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// that share one segment bus. Each digit is lit in turn for SCAN_DIV clock
// cycles. Digits can be blanked or made to blink one at a time.
//
// Display data is double-buffered. A load strobe writes into a pending
// buffer, and that buffer is copied into the active buffer only at a frame
// boundary. A frame therefore never shows a mix of old and new data.
//
// Parameters
//   NUM_DIGITS   number of multiplexed digits (1..8)
//   SCAN_DIV     clock cycles each digit stays lit (>= 2)
//   BLINK_DIV    frames per blink half-period (>= 1)
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous reset, active-high
//   load_i         one-cycle strobe that captures the three data inputs below
//   digit_data_i   one hex nibble per digit, digit i = [4i+3:4i]
//   en_mask_i      1 = digit shown, 0 = digit blanked
//   blink_mask_i   1 = digit blanks during the blink off phase
//   seg_o          segments gfedcba, active-low, registered
//   an_o           anode selects, active-low, one-hot-low, registered
//   frame_done_o   one-cycle pulse in the last cycle of the last digit slot
//   busy_o         high while a loaded update waits for its frame swap
// ---------------------------------------------------------------------------
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digit_data_i,
    input  logic [NUM_DIGITS-1:0]   en_mask_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_done_o,
    output logic                    busy_o
);

    // Counter widths. The max(1, ...) guards keep every vector at least one
    // bit wide for the degenerate parameter values (one digit, or a blink
    // period of one frame).
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan and blink timing state
    logic [SCAN_W-1:0]  scanCnt_q,  scanCnt_d;
    logic [IDX_W-1:0]   digIdx_q,   digIdx_d;
    logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
    logic               blinkOn_q,  blinkOn_d;

    // Active buffer: the data currently being scanned out
    logic [4*NUM_DIGITS-1:0] actData_q,  actData_d;
    logic [NUM_DIGITS-1:0]   actEn_q,    actEn_d;
    logic [NUM_DIGITS-1:0]   actBlink_q, actBlink_d;

    // Pending buffer: the most recent load, waiting for a frame boundary
    logic [4*NUM_DIGITS-1:0] pendData_q,  pendData_d;
    logic [NUM_DIGITS-1:0]   pendEn_q,    pendEn_d;
    logic [NUM_DIGITS-1:0]   pendBlink_q, pendBlink_d;
    logic                    pendValid_q, pendValid_d;

    // Registered pin drivers
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q,  an_d;

    // Decoded per-cycle conditions
    logic                  slotEnd;
    logic                  frameEnd;
    logic [3:0]            curNibble;
    logic                  curEn;
    logic                  curBlink;
    logic [NUM_DIGITS-1:0] curAnSel;
    logic                  curVisible;

    // Hex-to-segment lookup. The result is active-low in gfedcba order, and
    // b and d use their lower-case glyphs so they are not mistaken for 8 and 0.
    function automatic logic [6:0] decodeHex(input logic [3:0] nibble);
        logic [6:0] segs;
        case (nibble)
            4'h0:    segs = 7'h40;
            4'h1:    segs = 7'h79;
            4'h2:    segs = 7'h24;
            4'h3:    segs = 7'h30;
            4'h4:    segs = 7'h19;
            4'h5:    segs = 7'h12;
            4'h6:    segs = 7'h02;
            4'h7:    segs = 7'h78;
            4'h8:    segs = 7'h00;
            4'h9:    segs = 7'h10;
            4'hA:    segs = 7'h08;
            4'hB:    segs = 7'h03;
            4'hC:    segs = 7'h46;
            4'hD:    segs = 7'h21;
            4'hE:    segs = 7'h06;
            default: segs = 7'h0E;
        endcase
        return segs;
    endfunction

    // A digit slot ends on the terminal scan count. The frame ends when that
    // happens on the last digit. frame_done is taken straight from these
    // registered counters, so it is high during exactly that one cycle. The
    // buffer swap and the blink update happen on the clock edge that closes
    // that cycle.
    always_comb begin
        slotEnd  = (scanCnt_q == SCAN_LAST);
        frameEnd = slotEnd && (digIdx_q == IDX_LAST);
    end

    // Select the current digit's nibble, enable, blink bit and anode line.
    // The equality compare against every legal index, instead of a variable
    // part-select, means an index outside the digit range cannot select
    // anything.
    always_comb begin
        curNibble = 4'h0;
        curEn     = 1'b0;
        curBlink  = 1'b0;
        curAnSel  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digIdx_q == IDX_W'(i)) begin
                curNibble   = actData_q[4*i +: 4];
                curEn       = actEn_q[i];
                curBlink    = actBlink_q[i];
                curAnSel[i] = 1'b0;
            end
        end
        curVisible = curEn && (!curBlink || blinkOn_q);
    end

    // Scan counter and digit index. The index moves on only at the end of a
    // slot, and it wraps from the last digit straight back to digit 0.
    always_comb begin
        scanCnt_d = scanCnt_q + 1'b1;
        digIdx_d  = digIdx_q;
        if (slotEnd) begin
            scanCnt_d = '0;
            if (digIdx_q == IDX_LAST) begin
                digIdx_d = '0;
            end else begin
                digIdx_d = digIdx_q + 1'b1;
            end
        end
    end

    // Blink phase. Frames are counted only at frame_done, so the phase can
    // flip only when digit 0 is about to be shown. A blinking digit therefore
    // never changes state partway through a frame.
    always_comb begin
        blinkCnt_d = blinkCnt_q;
        blinkOn_d  = blinkOn_q;
        if (frameEnd) begin
            if (blinkCnt_q == BLINK_LAST) begin
                blinkCnt_d = '0;
                blinkOn_d  = !blinkOn_q;
            end else begin
                blinkCnt_d = blinkCnt_q + 1'b1;
            end
        end
    end

    // Double buffer update. A load arriving on the frame-end cycle goes
    // directly into the active buffer. This keeps a frame of latency off the
    // fast path, and busy never rises for that load. Any other load
    // overwrites the pending buffer, so the last write before the swap wins.
    always_comb begin
        actData_d   = actData_q;
        actEn_d     = actEn_q;
        actBlink_d  = actBlink_q;
        pendData_d  = pendData_q;
        pendEn_d    = pendEn_q;
        pendBlink_d = pendBlink_q;
        pendValid_d = pendValid_q;
        if (frameEnd) begin
            pendValid_d = 1'b0;
            if (load_i) begin
                actData_d  = digit_data_i;
                actEn_d    = en_mask_i;
                actBlink_d = blink_mask_i;
            end else if (pendValid_q) begin
                actData_d  = pendData_q;
                actEn_d    = pendEn_q;
                actBlink_d = pendBlink_q;
            end
        end else if (load_i) begin
            pendData_d  = digit_data_i;
            pendEn_d    = en_mask_i;
            pendBlink_d = blink_mask_i;
            pendValid_d = 1'b1;
        end
    end

    // Pin drivers for the digit selected this cycle. They reach the pins one
    // clock later, so each digit occupies a full SCAN_DIV-cycle window. A
    // hidden digit also turns its anode off, so the shared bus does not
    // ghost into it.
    always_comb begin
        if (curVisible) begin
            seg_d = decodeHex(curNibble);
            an_d  = curAnSel;
        end else begin
            seg_d = SEG_BLANK;
            an_d  = '1;
        end
    end

    // All state lives here. Reset blanks the display, restarts the scan at
    // digit 0 with the blink phase on, and drops any pending load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scanCnt_q   <= '0;
            digIdx_q    <= '0;
            blinkCnt_q  <= '0;
            blinkOn_q   <= 1'b1;
            actData_q   <= '0;
            actEn_q     <= '0;
            actBlink_q  <= '0;
            pendData_q  <= '0;
            pendEn_q    <= '0;
            pendBlink_q <= '0;
            pendValid_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
        end else begin
            scanCnt_q   <= scanCnt_d;
            digIdx_q    <= digIdx_d;
            blinkCnt_q  <= blinkCnt_d;
            blinkOn_q   <= blinkOn_d;
            actData_q   <= actData_d;
            actEn_q     <= actEn_d;
            actBlink_q  <= actBlink_d;
            pendData_q  <= pendData_d;
            pendEn_q    <= pendEn_d;
            pendBlink_q <= pendBlink_d;
            pendValid_q <= pendValid_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    // Output assignments
    always_comb begin
        seg_o        = seg_q;
        an_o         = an_q;
        frame_done_o = frameEnd;
        busy_o       = pendValid_q;
    end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_mux
//
// Directed testbench for seven_seg_scan_mux with 4 digits, a 4-cycle digit
// slot and a 2-frame blink half-period. Expected segment and anode values
// per digit come from a hand-filled vector table and a few hand-written
// multi-frame sequences.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digitData = '0;
    logic [3:0]  enMask = '0;
    logic [3:0]  blinkMask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frameDone;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // One table entry: data to load, plus the expected segments and anodes
    // for digits 3..0 (element [d] belongs to digit d).
    typedef struct {
        logic [15:0]     data;
        logic [3:0]      en;
        logic [3:0][6:0] expSeg;
        logic [3:0][3:0] expAn;
    } vec_t;

    vec_t vecs [5];

    seven_seg_scan_mux #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .digit_data_i(digitData),
        .en_mask_i   (enMask),
        .blink_mask_i(blinkMask),
        .seg_o       (seg),
        .an_o        (an),
        .frame_done_o(frameDone),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Compare one sampled value against its expected value
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive a one-cycle load from a negedge. Returns at the next negedge.
    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] en,
                                 input logic [3:0] blink);
        digitData = data;
        enMask    = en;
        blinkMask = blink;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Hold reset for two edges. Returns at the negedge where the design
    // sits in cycle 0 of frame 0.
    task automatic doReset();
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Step negedge by negedge until frame_done is high, up to a bound
    task automatic waitFrameDone(input string tag);
        int n = 0;
        while (frameDone !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (frameDone !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s frame_done timeout got %b expected 1", tag, frameDone);
        end
    endtask

    // Check one whole frame. Call at the negedge where the design is in
    // cycle 0 of the frame. Returns at cycle 0 of the following frame.
    task automatic checkFrame(input logic [3:0][6:0] expSeg,
                              input logic [3:0][3:0] expAn,
                              input logic expBusy, input string tag);
        int d;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            d = i / 4;
            checkOutput($sformatf("%s seg d%0d c%0d", tag, d, i), {1'b0, seg}, {1'b0, expSeg[d]});
            checkOutput($sformatf("%s an d%0d c%0d", tag, d, i), {4'b0, an}, {4'b0, expAn[d]});
            checkOutput($sformatf("%s busy c%0d", tag, i), {7'b0, busy}, {7'b0, expBusy});
            checkOutput($sformatf("%s frame_done c%0d", tag, i), {7'b0, frameDone},
                        {7'b0, (i == 14)});
        end
    endtask

    initial begin
        logic blinkOnExp;

        // Segments are listed for digit 3 first, down to digit 0
        vecs[0] = '{16'h3A1B, 4'hF, {7'h30, 7'h08, 7'h79, 7'h03}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[1] = '{16'h7F5C, 4'hA, {7'h78, 7'h7F, 7'h12, 7'h7F}, {4'h7, 4'hF, 4'hD, 4'hF}};
        vecs[2] = '{16'h9E6D, 4'hF, {7'h10, 7'h06, 7'h02, 7'h21}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[3] = '{16'h8402, 4'h7, {7'h7F, 7'h19, 7'h40, 7'h24}, {4'hF, 4'hB, 4'hD, 4'hE}};
        vecs[4] = '{16'hCF18, 4'hF, {7'h46, 7'h0E, 7'h79, 7'h00}, {4'h7, 4'hB, 4'hD, 4'hE}};

        // Reset, then idle: blank display, frame_done every 16 cycles
        $display("[TB] reset and idle");
        doReset();
        for (int c = 0; c < 40; c++) begin
            checkOutput($sformatf("idle seg c%0d", c), {1'b0, seg}, 8'h7F);
            checkOutput($sformatf("idle an c%0d", c), {4'b0, an}, 8'h0F);
            checkOutput($sformatf("idle busy c%0d", c), {7'b0, busy}, 8'h00);
            checkOutput($sformatf("idle frame_done c%0d", c), {7'b0, frameDone},
                        {7'b0, ((c % 16) == 15)});
            @(negedge clk);
        end

        // Table vectors: load mid-frame, busy until swap, then a full frame
        $display("[TB] table vectors");
        for (int v = 0; v < 5; v++) begin
            waitFrameDone($sformatf("vec%0d", v));
            @(negedge clk);
            repeat (5) @(negedge clk);
            applyStimulus(vecs[v].data, vecs[v].en, 4'h0);
            checkOutput($sformatf("vec%0d busy after load", v), {7'b0, busy}, 8'h01);
            waitFrameDone($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d busy at swap", v), {7'b0, busy}, 8'h01);
            @(negedge clk);
            checkFrame(vecs[v].expSeg, vecs[v].expAn, 1'b0, $sformatf("vec%0d", v));
        end

        // Two loads in one frame: only the second is ever displayed
        $display("[TB] last write wins");
        waitFrameDone("lww");
        @(negedge clk);
        repeat (2) @(negedge clk);
        applyStimulus(16'h1111, 4'hF, 4'h0);
        repeat (3) @(negedge clk);
        applyStimulus(16'h2222, 4'hF, 4'h0);
        checkOutput("lww busy", {7'b0, busy}, 8'h01);
        waitFrameDone("lww");
        @(negedge clk);
        checkFrame({7'h24, 7'h24, 7'h24, 7'h24}, {4'h7, 4'hB, 4'hD, 4'hE}, 1'b0, "lww");

        // Load on the frame_done cycle: bypass, busy never rises
        $display("[TB] load on frame boundary");
        waitFrameDone("bypass");
        applyStimulus(16'h4567, 4'hF, 4'h0);
        checkOutput("bypass busy", {7'b0, busy}, 8'h00);
        checkFrame({7'h19, 7'h12, 7'h02, 7'h78}, {4'h7, 4'hB, 4'hD, 4'hE}, 1'b0, "bypass");

        // Blinking digit 0 and steady digit 2, with digits 1 and 3 disabled.
        // Blink is on for frames 0,1 after reset, off for 2,3, and so on.
        $display("[TB] blink");
        doReset();
        applyStimulus(16'h0508, 4'b0101, 4'b0001);
        checkOutput("blink busy after load", {7'b0, busy}, 8'h01);
        waitFrameDone("blink");
        checkOutput("blink busy at swap", {7'b0, busy}, 8'h01);
        @(negedge clk);
        for (int f = 1; f <= 6; f++) begin
            blinkOnExp = (((f / 2) % 2) == 0);
            checkFrame({7'h7F, 7'h12, 7'h7F, blinkOnExp ? 7'h00 : 7'h7F},
                       {4'hF, 4'hB, 4'hF, blinkOnExp ? 4'hE : 4'hF},
                       1'b0, $sformatf("blink f%0d", f));
        end

        // Reset while an update is pending: blank and the update is lost
        $display("[TB] reset while busy");
        repeat (3) @(negedge clk);
        applyStimulus(16'hFFFF, 4'hF, 4'h0);
        checkOutput("rstbusy busy before reset", {7'b0, busy}, 8'h01);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstbusy seg", {1'b0, seg}, 8'h7F);
        checkOutput("rstbusy an", {4'b0, an}, 8'h0F);
        checkOutput("rstbusy busy", {7'b0, busy}, 8'h00);
        checkOutput("rstbusy frame_done", {7'b0, frameDone}, 8'h00);
        checkFrame({4{7'h7F}}, {4{4'hF}}, 1'b0, "rstbusy f0");
        checkFrame({4{7'h7F}}, {4{4'hF}}, 1'b0, "rstbusy f1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
